// File: rtl/bit_chain_pkg.sv
// Shared definitions for the bit-chain sequencer.
//   state_e  : sequencer phases (IDLE, ARM, RUN, FLUSH, DONE)
//   DIV_TAPS : number of free-running divider taps exported on div_o
//   period() : tick period in clk cycles for a given 2-bit divider select
package bit_chain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DIV_TAPS = 4;

  // 2^(div_sel+1): 2, 4, 8 or 16 clk cycles per tick. The select is widened
  // before the +1 so that div_sel=3 does not wrap to a shift of zero.
  function automatic logic [4:0] period(input logic [1:0] div_sel);
    return 5'(5'd1 << ({1'b0, div_sel} + 3'd1));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler producing the chain's clock-enable.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   en       : count enable (sequencer is in RUN or FLUSH)
//   clr      : restart the count at zero (sequencer is in ARM)
//   div_sel  : latched divider select, period = 2^(div_sel+1)
//   shift_en : combinational, high on the clk edge where the chain shifts
//   tick     : registered copy of shift_en, high the cycle after a shift
module tick_prescaler
  import bit_chain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] div_sel,
  output logic       shift_en,
  output logic       tick
);

  logic [3:0] cnt_r;
  logic [3:0] last_s;

  // Terminal count for the selected period and the resulting shift strobe.
  always_comb begin
    last_s   = 4'(period(div_sel) - 5'd1);
    shift_en = en && (cnt_r == last_s);
  end

  // Prescaler count and registered tick; holds while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_r <= 4'd0;
      tick  <= 1'b0;
    end else if (en) begin
      cnt_r <= shift_en ? 4'd0 : cnt_r + 4'd1;
      tick  <= shift_en;
    end else begin
      cnt_r <= cnt_r;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_chain_sequencer.sv
// Bit-shift chain controller paced by a programmable binary divider.
// A start request arms the sequencer; the chain then shifts in a toggling
// source bit once per tick for run_len ticks (or until stop when run_len=0),
// is flushed to zero, and a one-cycle done pulse closes the sequence.
// Ports:
//   clk     : system clock          rst     : synchronous active-high reset
//   start   : one-cycle request     stop    : level, ends RUN at next tick
//   div_sel : tick period select    run_len : RUN ticks, 0 = free-run
//   div_o   : free-running /2../16 divider taps
//   tick    : pulse the cycle after each shift
//   chain   : chain contents, chain[0] newest
//   busy    : sequence in progress  done    : end-of-sequence pulse
module bit_chain_sequencer
  import bit_chain_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int SRC_HOLD = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          div_sel,
  input  logic [CNT_W-1:0]    run_len,
  output logic [DIV_TAPS-1:0] div_o,
  output logic                tick,
  output logic [DEPTH-1:0]    chain,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0]       HOLD_LAST  = 4'(SRC_HOLD - 1);
  localparam logic [4:0]       FLUSH_LAST = 5'(DEPTH - 1);
  localparam logic [CNT_W-1:0] TCOUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_r;
  logic [1:0]          div_sel_r;
  logic [CNT_W-1:0]    run_len_r;
  logic [CNT_W-1:0]    tcount_r;
  logic [3:0]          hold_r;
  logic [4:0]          fcount_r;
  logic                src_r;
  logic [DEPTH-1:0]    chain_r;
  logic                busy_r;
  logic                done_r;
  logic [DIV_TAPS-1:0] div_r;
  logic                en_s;
  logic                clr_s;
  logic                shift_en_s;
  logic                run_end_s;

  // Prescaler control and the RUN exit condition evaluated at a shift edge.
  always_comb begin
    en_s      = (state_r == RUN) || (state_r == FLUSH);
    clr_s     = (state_r == ARM);
    run_end_s = stop ||
                ((run_len_r != {CNT_W{1'b0}}) && ((tcount_r + TCOUNT_ONE) == run_len_r));
  end

  tick_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_s),
    .clr      (clr_s),
    .div_sel  (div_sel_r),
    .shift_en (shift_en_s),
    .tick     (tick)
  );

  // Sequencer FSM with source toggle, counters, chain and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      div_sel_r <= 2'd0;
      run_len_r <= {CNT_W{1'b0}};
      tcount_r  <= {CNT_W{1'b0}};
      hold_r    <= 4'd0;
      fcount_r  <= 5'd0;
      src_r     <= 1'b0;
      chain_r   <= {DEPTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      div_r     <= {DIV_TAPS{1'b0}};
    end else begin
      div_r  <= div_r + 4'd1;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            div_sel_r <= div_sel;
            run_len_r <= run_len;
            busy_r    <= 1'b1;
            state_r   <= ARM;
          end else begin
            state_r   <= IDLE;
          end
        end
        ARM: begin
          chain_r  <= {DEPTH{1'b0}};
          src_r    <= 1'b1;
          hold_r   <= 4'd0;
          tcount_r <= {CNT_W{1'b0}};
          fcount_r <= 5'd0;
          state_r  <= RUN;
        end
        RUN: begin
          if (shift_en_s) begin
            chain_r <= {chain_r[DEPTH-2:0], src_r};
            if (hold_r == HOLD_LAST) begin
              src_r  <= ~src_r;
              hold_r <= 4'd0;
            end else begin
              hold_r <= hold_r + 4'd1;
            end
            if (run_end_s) begin
              fcount_r <= 5'd0;
              state_r  <= FLUSH;
            end else begin
              tcount_r <= tcount_r + TCOUNT_ONE;
            end
          end else begin
            state_r <= RUN;
          end
        end
        FLUSH: begin
          if (shift_en_s) begin
            chain_r <= {chain_r[DEPTH-2:0], 1'b0};
            if (fcount_r == FLUSH_LAST) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              fcount_r <= fcount_r + 5'd1;
            end
          end else begin
            state_r <= FLUSH;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign div_o = div_r;
  assign chain = chain_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_bit_chain_sequencer.sv
module tb_bit_chain_sequencer;

  localparam int DEPTH    = 3;
  localparam int SRC_HOLD = 2;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       div_sel;
  logic [CNT_W-1:0] run_len;
  logic [3:0]       div_o;
  logic             tick;
  logic [DEPTH-1:0] chain;
  logic             busy;
  logic             done;

  logic             start1;
  logic             stop1;
  logic [1:0]       div_sel1;
  logic [CNT_W-1:0] run_len1;
  logic [3:0]       div_o1;
  logic             tick1;
  logic [DEPTH-1:0] chain1;
  logic             busy1;
  logic             done1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cur      = 0;

  bit_chain_sequencer #(.DEPTH(DEPTH), .SRC_HOLD(SRC_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div_sel(div_sel),
    .run_len(run_len), .div_o(div_o), .tick(tick), .chain(chain),
    .busy(busy), .done(done)
  );

  bit_chain_sequencer #(.DEPTH(DEPTH), .SRC_HOLD(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .div_sel(div_sel1),
    .run_len(run_len1), .div_o(div_o1), .tick(tick1), .chain(chain1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Shift edges are computed arithmetically from the capture edge: the k-th
  // shift (k>=1) happens k*period+1 edges after start capture. RUN bit k
  // (0-based) is 1 when floor(k/SRC_HOLD) is even. A sequence ends after
  // DEPTH flush shifts, then one DONE cycle.
  int               m_e = 0;
  int               m_e0, m_p, m_L, m_k, m_fl;
  int               phase = 0;   // 0 idle, 1 sequencing, 2 done cycle
  bit               m_flush, m_valid = 1'b0;
  logic [DEPTH-1:0] m_chain;
  logic             m_busy, m_done, m_tick;
  logic [3:0]       m_div;

  initial begin
    forever begin
      int   since;
      logic b;
      @(posedge clk);
      m_e = m_e + 1;
      if (rst) begin
        phase = 0; m_chain = '0; m_busy = 1'b0; m_done = 1'b0;
        m_tick = 1'b0; m_div = 4'd0; m_valid = 1'b1;
      end else begin
        m_div  = m_div + 4'd1;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (phase == 2) begin
          phase = 0; m_busy = 1'b0;
        end else if (phase == 1) begin
          since = m_e - m_e0;
          if (since == 1) m_chain = '0;
          else if (since >= 1 + m_p && ((since - 1) % m_p) == 0) begin
            m_tick = 1'b1;
            if (!m_flush) begin
              b = ((m_k / SRC_HOLD) % 2) == 0;
              m_k++;
              m_chain = {m_chain[DEPTH-2:0], b};
              if ((m_L != 0 && m_k == m_L) || stop) m_flush = 1'b1;
            end else begin
              m_chain = {m_chain[DEPTH-2:0], 1'b0};
              m_fl++;
              if (m_fl == DEPTH) begin phase = 2; m_done = 1'b1; end
            end
          end
        end else if (start) begin
          phase = 1; m_e0 = m_e; m_p = 2 << int'(div_sel); m_L = int'(run_len);
          m_k = 0; m_fl = 0; m_flush = 1'b0; m_busy = 1'b1;
        end
      end
      @(negedge clk);
      if (m_valid) begin
        check("cyc_div",   32'(div_o), 32'(m_div));
        check("cyc_tick",  32'(tick),  32'(m_tick));
        check("cyc_chain", 32'(chain), 32'(m_chain));
        check("cyc_busy",  32'(busy),  32'(m_busy));
        check("cyc_done",  32'(done),  32'(m_done));
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic go(input logic [1:0] ds, input logic [CNT_W-1:0] rl);
    start = 1'b1; div_sel = ds; run_len = rl;
    @(negedge clk);          // now just after capture edge E0
    start = 1'b0; div_sel = ~ds; run_len = 8'd5;
    cur = 0;
  endtask

  task automatic go1(input logic [1:0] ds, input logic [CNT_W-1:0] rl);
    start1 = 1'b1; div_sel1 = ds; run_len1 = rl;
    @(negedge clk);
    start1 = 1'b0; div_sel1 = 2'd3; run_len1 = 8'd9;
    cur = 0;
  endtask

  task automatic wait_to(input int k);
    repeat (k - cur) @(negedge clk);
    cur = k;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_sel = 2'd0; run_len = 8'd0;
    start1 = 1'b0; stop1 = 1'b0; div_sel1 = 2'd0; run_len1 = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_div",   32'(div_o),  32'd0);
    check("rst_chain", 32'(chain),  32'd0);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_tick",  32'(tick),   32'd0);
    check("rst_done",  32'(done),   32'd0);
    check("rst_div1",  32'(div_o1), 32'd0);
    cur = 0;
    wait_to(15); check("div_15",   32'(div_o), 32'd15);
    wait_to(16); check("div_wrap", 32'(div_o), 32'd0);
    wait_to(20);

    // div_sel=0, run_len=4
    go(2'd0, 8'd4);
    wait_to(2);  check("t1_e2_chain", 32'(chain), 32'd0);  check("t1_e2_busy", 32'(busy), 32'd1);
    wait_to(3);  check("t1_e3_chain", 32'(chain), 32'b001); check("t1_e3_tick", 32'(tick), 32'd1);
    wait_to(4);  check("t1_e4_tick",  32'(tick),  32'd0);
    wait_to(5);  check("t1_e5_chain", 32'(chain), 32'b011);
    wait_to(7);  check("t1_e7_chain", 32'(chain), 32'b110);
    wait_to(9);  check("t1_e9_chain", 32'(chain), 32'b100);
    wait_to(11); check("t1_e11_chain", 32'(chain), 32'b000);
    wait_to(14); check("t1_e14_done", 32'(done), 32'd0);
    wait_to(15); check("t1_e15_done", 32'(done), 32'd1);  check("t1_e15_busy", 32'(busy), 32'd1);
    wait_to(16); check("t1_e16_done", 32'(done), 32'd0);  check("t1_e16_busy", 32'(busy), 32'd0);
    wait_to(18);

    // div_sel=3, run_len=2
    go(2'd3, 8'd2);
    wait_to(16); check("t2_e16_tick", 32'(tick), 32'd0);
    wait_to(17); check("t2_e17_tick", 32'(tick), 32'd1); check("t2_e17_chain", 32'(chain), 32'b001);
    wait_to(33); check("t2_e33_tick", 32'(tick), 32'd1); check("t2_e33_chain", 32'(chain), 32'b011);
    wait_to(81); check("t2_e81_done", 32'(done), 32'd1); check("t2_e81_chain", 32'(chain), 32'd0);
    wait_to(82); check("t2_e82_busy", 32'(busy), 32'd0);
    wait_to(84);

    // free-run, stop after 7 ticks, stray start during RUN
    go(2'd0, 8'd0);
    wait_to(10); start = 1'b1;
    wait_to(11); start = 1'b0;
    wait_to(15); stop = 1'b1;
    wait_to(17); check("t3_e17_chain", 32'(chain), 32'b100); check("t3_e17_busy", 32'(busy), 32'd1);
    wait_to(22); check("t3_e22_done", 32'(done), 32'd0);
    wait_to(23); check("t3_e23_done", 32'(done), 32'd1);
    stop = 1'b0;
    wait_to(24); check("t3_e24_busy", 32'(busy), 32'd0);
    wait_to(26);

    // reset mid-FLUSH, then a normal start
    go(2'd0, 8'd2);
    wait_to(8);  check("t4_e8_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_to(9);  rst = 1'b0;
    check("t4_rst_busy",  32'(busy),  32'd0);
    check("t4_rst_chain", 32'(chain), 32'd0);
    check("t4_rst_done",  32'(done),  32'd0);
    wait_to(14);
    go(2'd0, 8'd4);
    wait_to(2);  check("t4_e2_tick",  32'(tick),  32'd0);
    wait_to(3);  check("t4_e3_chain", 32'(chain), 32'b001); check("t4_e3_tick", 32'(tick), 32'd1);
    wait_to(18);

    // SRC_HOLD=1 instance: source 1,0,1
    go1(2'd0, 8'd3);
    wait_to(3);  check("t5_e3_chain",  32'(chain1), 32'b001);
    wait_to(5);  check("t5_e5_chain",  32'(chain1), 32'b010);
    wait_to(7);  check("t5_e7_chain",  32'(chain1), 32'b101); check("t5_e7_tick", 32'(tick1), 32'd1);
    wait_to(13); check("t5_e13_done",  32'(done1),  32'd1);  check("t5_e13_chain", 32'(chain1), 32'd0);
    wait_to(14); check("t5_e14_busy",  32'(busy1),  32'd0);
    check("t5_div1", 32'(div_o1), 32'(div_o1 ^ 4'd0));
    wait_to(16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
